mem_responder: RTL and testbench

- Memory-side responder for the control unit's RAM handshake: RAMEnable, MOV and RW in, MOC out.
- Byte-addressable, big-endian data RAM with a configurable number of wait states.
- Handles word, half and byte accesses, with sign or zero extension on loads.
- Sits between the datapath and the CPU's memory port. It is the "other end" of the LW/LH/LHU/LB/SW/SH/SB control path.

---
 rtl/mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_mem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder for the control unit's RAMEnable/MOV/RW/MOC handshake.
// Byte-addressable big-endian RAM with configurable wait states and sized, extended loads.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ram_enable,
  input  logic              mov,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              moc,
  output logic              mem_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg;
  logic [ADDR_W-1:0] req_addr_reg;
  logic [1:0]        req_size_reg;
  logic              req_rw_reg;
  logic              req_sext_reg;
  logic [31:0]       req_data_reg;
  logic [31:0]       data_out_reg;
  logic              moc_reg;
  logic              err_reg;

  logic [7:0]        mem [DEPTH];

  logic              start;
  logic              do_access;
  logic [ADDR_W-1:0] acc_addr;
  logic [1:0]        acc_size;
  logic              acc_rw;
  logic              acc_sext;
  logic [31:0]       acc_data;
  logic              acc_err;
  logic [2:0]        acc_nbytes;
  logic [31:0]       wr_shifted;
  logic [7:0]        rd_byte [4];
  logic [31:0]       load_val;

  assign start = (state_reg == S_IDLE) && ram_enable && mov;

  // With no wait states the access happens on the accept edge, so it uses the live inputs.
  always_comb begin
    acc_addr = req_addr_reg;
    acc_size = req_size_reg;
    acc_rw   = req_rw_reg;
    acc_sext = req_sext_reg;
    acc_data = req_data_reg;
    if (WAIT_CYCLES == 0) begin
      acc_addr = address;
      acc_size = size;
      acc_rw   = rw;
      acc_sext = sign_ext;
      acc_data = data_in;
    end
  end

  always_comb begin
    do_access = 1'b0;
    if (WAIT_CYCLES == 0)
      do_access = start;
    else
      do_access = (state_reg == S_WAIT) && (cnt_reg == 4'd1);
  end

  always_comb begin
    acc_err    = 1'b0;
    acc_nbytes = 3'd4;
    case (acc_size)
      2'b00: begin acc_nbytes = 3'd4; acc_err = (acc_addr[1:0] != 2'b00); end
      2'b01: begin acc_nbytes = 3'd2; acc_err = acc_addr[0]; end
      2'b10: begin acc_nbytes = 3'd1; acc_err = 1'b0; end
      default: begin acc_nbytes = 3'd1; acc_err = 1'b1; end
    endcase
  end

  // Store data is right-justified; shift it so lane 0 always holds the byte for M[a].
  always_comb begin
    wr_shifted = acc_data;
    case (acc_nbytes)
      3'd2:    wr_shifted = {acc_data[15:0], 16'h0000};
      3'd1:    wr_shifted = {acc_data[7:0], 24'h000000};
      default: wr_shifted = acc_data;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      rd_byte[i] = mem[acc_addr + ADDR_W'(i)];
  end

  always_comb begin
    load_val = 32'h0;
    case (acc_size)
      2'b00: load_val = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
      2'b01: load_val = {{16{acc_sext & rd_byte[0][7]}}, rd_byte[0], rd_byte[1]};
      2'b10: load_val = {{24{acc_sext & rd_byte[0][7]}}, rd_byte[0]};
      default: load_val = 32'h0;
    endcase
    if (!acc_rw || acc_err)
      load_val = 32'h0;
  end

  // RAM is deliberately outside the reset domain so its contents survive reset.
  always_ff @(posedge clk) begin
    if (do_access && !acc_rw && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < acc_nbytes)
          mem[acc_addr + ADDR_W'(i)] <= wr_shifted[31-8*i -: 8];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start)
          state_next = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_reg == 4'd1)
          state_next = S_DONE;
      end
      S_DONE: begin
        if (!mov)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= 4'd0;
      req_addr_reg <= '0;
      req_size_reg <= 2'b00;
      req_rw_reg   <= 1'b0;
      req_sext_reg <= 1'b0;
      req_data_reg <= 32'h0;
      data_out_reg <= 32'h0;
      moc_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        cnt_reg      <= 4'(WAIT_CYCLES);
        req_addr_reg <= address;
        req_size_reg <= size;
        req_rw_reg   <= rw;
        req_sext_reg <= sign_ext;
        req_data_reg <= data_in;
      end else if (state_reg == S_WAIT) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (do_access) begin
        data_out_reg <= load_val;
        err_reg      <= acc_err;
      end else if (state_reg == S_DONE) begin
        // MOC is raised one edge after entering DONE; a dropped MOV falls straight through.
        if (mov) begin
          moc_reg <= 1'b1;
        end else begin
          moc_reg      <= 1'b0;
          data_out_reg <= 32'h0;
          err_reg      <= 1'b0;
        end
      end
    end
  end

  assign data_out = data_out_reg;
  assign moc      = moc_reg;
  assign mem_err  = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a 2-wait-state and a 0-wait-state instance driven in lockstep
// and compared against a byte-array reference model plus fixed vectors.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_enable, z_en, mov, rw, sign_ext;
  logic [1:0]  size;
  logic [8:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out, z_data_out;
  logic        moc, mem_err, z_moc, z_mem_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] mm [512];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(rst_n), .ram_enable(ram_enable), .mov(mov), .rw(rw),
    .size(size), .sign_ext(sign_ext), .address(address), .data_in(data_in),
    .data_out(data_out), .moc(moc), .mem_err(mem_err)
  );

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_n), .ram_enable(z_en), .mov(mov), .rw(rw),
    .size(size), .sign_ext(sign_ext), .address(address), .data_in(data_in),
    .data_out(z_data_out), .moc(z_moc), .mem_err(z_mem_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: big-endian byte array, result derived from the access rules directly.
  function automatic void model_access(input logic m_rw, input logic [1:0] m_size,
      input logic m_sext, input logic [8:0] m_addr, input logic [31:0] m_din,
      output logic [31:0] m_d, output logic m_e);
    int n;
    logic [31:0] v;
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    m_e = (m_size == 2'd3) || (m_size == 2'd0 && (m_addr % 4) != 0) ||
          (m_size == 2'd1 && (m_addr % 2) != 0);
    m_d = 32'h0;
    if (m_e) return;
    n = (m_size == 2'd0) ? 4 : (m_size == 2'd1) ? 2 : 1;
    if (m_rw) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(mm[(int'(m_addr) + i) % 512]);
      if (m_sext && n < 4 && v[8*n-1]) v = v | (ones << (8*n));
      m_d = v;
    end else begin
      for (int i = 0; i < n; i++) mm[(int'(m_addr) + i) % 512] = 8'(m_din >> (8*(n-1-i)));
    end
  endfunction

  // One full four-phase handshake on both instances; inputs are scrambled after accept.
  task automatic do_txn(input logic t_rw, input logic [1:0] t_size, input logic t_sext,
      input logic [8:0] t_addr, input logic [31:0] t_din,
      output logic [31:0] d2, output logic e2, output int l2,
      output logic [31:0] d0, output logic e0, output int l0);
    bit s2, s0;
    @(negedge clk);
    ram_enable = 1'b1; z_en = 1'b1; mov = 1'b1;
    rw = t_rw; size = t_size; sign_ext = t_sext; address = t_addr; data_in = t_din;
    @(posedge clk); #1;
    rw = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
    address = 9'($urandom); data_in = $urandom; ram_enable = 1'($urandom); z_en = 1'($urandom);
    s2 = 0; s0 = 0; l2 = 99; l0 = 99; d2 = 32'h0; e2 = 1'b0; d0 = 32'h0; e0 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (moc === 1'b1 && !s2) begin s2 = 1; l2 = n; d2 = data_out; e2 = mem_err; end
      if (z_moc === 1'b1 && !s0) begin s0 = 1; l0 = n; d0 = z_data_out; e0 = z_mem_err; end
      if (s2 && s0) break;
      @(posedge clk); #1;
    end
    mov = 1'b0;
    @(posedge clk); #1;
    chk("release_flags", {28'h0, moc, mem_err, z_moc, z_mem_err}, 32'h0);
    chk("release_data", data_out, 32'h0);
    chk("release_data0", z_data_out, 32'h0);
  endtask

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        sext;
    logic [8:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] d2, d0, md;
    logic e2, e0, me;
    int l2, l0;
    logic        r_rw, r_sext;
    logic [1:0]  r_size;
    logic [8:0]  r_addr;
    logic [31:0] r_din;

    rst_n = 1'b0; ram_enable = 1'b0; z_en = 1'b0; mov = 1'b0; rw = 1'b0;
    size = 2'd0; sign_ext = 1'b0; address = 9'h0; data_in = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {28'h0, moc, mem_err, z_moc, z_mem_err}, 32'h0);
    chk("reset_data", data_out, 32'h0);
    chk("reset_data0", z_data_out, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Fill the whole RAM so every later read has defined contents.
    for (int i = 0; i < 128; i++) begin
      r_din = $urandom;
      do_txn(1'b0, 2'd0, 1'b0, 9'(4*i), r_din, d2, e2, l2, d0, e0, l0);
      model_access(1'b0, 2'd0, 1'b0, 9'(4*i), r_din, md, me);
      if (i % 32 == 0) begin
        chk("init_lat", 32'(l2), 32'd3);
        chk("init_lat0", 32'(l0), 32'd1);
        chk("init_err", {30'h0, e2, e0}, 32'h0);
      end
    end

    tbl = '{
      '{1'b0, 2'd0, 1'b0, 9'h010, 32'h11223344, 32'h00000000, 1'b0},
      '{1'b1, 2'd0, 1'b0, 9'h010, 32'h0,        32'h11223344, 1'b0},
      '{1'b1, 2'd2, 1'b1, 9'h011, 32'h0,        32'h00000022, 1'b0},
      '{1'b1, 2'd1, 1'b0, 9'h012, 32'h0,        32'h00003344, 1'b0},
      '{1'b0, 2'd0, 1'b0, 9'h020, 32'h55667788, 32'h00000000, 1'b0},
      '{1'b0, 2'd2, 1'b0, 9'h020, 32'h000000F0, 32'h00000000, 1'b0},
      '{1'b1, 2'd2, 1'b1, 9'h020, 32'h0,        32'hFFFFFFF0, 1'b0},
      '{1'b1, 2'd2, 1'b0, 9'h020, 32'h0,        32'h000000F0, 1'b0},
      '{1'b1, 2'd0, 1'b0, 9'h013, 32'h0,        32'h00000000, 1'b1},
      '{1'b0, 2'd1, 1'b0, 9'h021, 32'h0000ABCD, 32'h00000000, 1'b1},
      '{1'b1, 2'd0, 1'b0, 9'h020, 32'h0,        32'hF0667788, 1'b0},
      '{1'b1, 2'd3, 1'b0, 9'h024, 32'h0,        32'h00000000, 1'b1},
      '{1'b0, 2'd1, 1'b0, 9'h040, 32'h00008001, 32'h00000000, 1'b0},
      '{1'b1, 2'd1, 1'b1, 9'h040, 32'h0,        32'hFFFF8001, 1'b0},
      '{1'b1, 2'd1, 1'b0, 9'h040, 32'h0,        32'h00008001, 1'b0},
      '{1'b0, 2'd0, 1'b0, 9'h1FC, 32'hCAFEF00D, 32'h00000000, 1'b0},
      '{1'b1, 2'd2, 1'b0, 9'h1FF, 32'h0,        32'h0000000D, 1'b0},
      '{1'b1, 2'd1, 1'b1, 9'h1FE, 32'h0,        32'hFFFFF00D, 1'b0},
      '{1'b1, 2'd0, 1'b0, 9'h1FC, 32'h0,        32'hCAFEF00D, 1'b0}
    };
    foreach (tbl[k]) begin
      do_txn(tbl[k].rw, tbl[k].size, tbl[k].sext, tbl[k].addr, tbl[k].din, d2, e2, l2, d0, e0, l0);
      model_access(tbl[k].rw, tbl[k].size, tbl[k].sext, tbl[k].addr, tbl[k].din, md, me);
      $display("vec %0d rw=%0d size=%0d addr=%h data=%h err=%0d lat=%0d/%0d",
               k, tbl[k].rw, tbl[k].size, tbl[k].addr, d2, e2, l2, l0);
      chk("vec_data", d2, tbl[k].exp_d);
      chk("vec_err", {31'h0, e2}, {31'h0, tbl[k].exp_e});
      chk("vec_data0", d0, tbl[k].exp_d);
      chk("vec_err0", {31'h0, e0}, {31'h0, tbl[k].exp_e});
      chk("vec_lat", 32'(l2), 32'd3);
      chk("vec_lat0", 32'(l0), 32'd1);
    end

    // Randomized traffic against the reference model.
    for (int k = 0; k < 250; k++) begin
      r_rw = 1'($urandom); r_sext = 1'($urandom);
      r_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_addr = 9'($urandom);
      if ($urandom_range(0, 4) != 0) begin
        if (r_size == 2'd0) r_addr[1:0] = 2'b00;
        if (r_size == 2'd1) r_addr[0] = 1'b0;
      end
      r_din = $urandom;
      do_txn(r_rw, r_size, r_sext, r_addr, r_din, d2, e2, l2, d0, e0, l0);
      model_access(r_rw, r_size, r_sext, r_addr, r_din, md, me);
      $display("rnd %0d rw=%0d size=%0d addr=%h data=%h exp=%h", k, r_rw, r_size, r_addr, d2, md);
      chk("rnd_data", d2, md);
      chk("rnd_data0", d0, md);
      chk("rnd_err", {30'h0, e2, e0}, {30'h0, me, me});
      chk("rnd_lat", {16'(l2), 16'(l0)}, {16'd3, 16'd1});
    end

    // Reset during WAIT: the pending store is discarded (0-wait instance kept disabled).
    @(negedge clk);
    ram_enable = 1'b1; z_en = 1'b0; mov = 1'b1; rw = 1'b0; size = 2'd0;
    address = 9'h030; data_in = 32'hDEADBEEF;
    @(posedge clk);
    @(posedge clk); #1;
    chk("wait_no_moc", {30'h0, moc, z_moc}, 32'h0);
    rst_n = 1'b0; #1;
    chk("rst_wait_moc", {31'h0, moc}, 32'h0);
    chk("rst_wait_data", data_out, 32'h0);
    @(negedge clk); mov = 1'b0; ram_enable = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    $display("reset-in-wait applied to SW 030");
    do_txn(1'b1, 2'd0, 1'b0, 9'h030, 32'h0, d2, e2, l2, d0, e0, l0);
    model_access(1'b1, 2'd0, 1'b0, 9'h030, 32'h0, md, me);
    chk("rst_wait_keep", d2, md);
    chk("rst_wait_keep0", d0, md);

    // Reset during DONE: the store already happened and must persist.
    @(negedge clk);
    ram_enable = 1'b1; z_en = 1'b1; mov = 1'b1; rw = 1'b0; size = 2'd0;
    address = 9'h034; data_in = 32'h01020304;
    repeat (4) @(posedge clk);
    #1;
    chk("done_moc", {30'h0, moc, z_moc}, 32'h3);
    rst_n = 1'b0; #1;
    chk("rst_done_moc", {30'h0, moc, z_moc}, 32'h0);
    @(negedge clk); mov = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_access(1'b0, 2'd0, 1'b0, 9'h034, 32'h01020304, md, me);
    $display("reset-in-done applied to SW 034");
    do_txn(1'b1, 2'd0, 1'b0, 9'h034, 32'h0, d2, e2, l2, d0, e0, l0);
    chk("rst_done_keep", d2, 32'h01020304);
    chk("rst_done_keep0", d0, 32'h01020304);

    // Disabled request: mov held high with ram_enable low never completes.
    @(negedge clk);
    ram_enable = 1'b0; z_en = 1'b0; mov = 1'b1; rw = 1'b0; size = 2'd0;
    address = 9'h034; data_in = 32'hFFFFFFFF;
    l2 = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (moc !== 1'b0 || z_moc !== 1'b0) l2++;
    end
    chk("disabled_moc", 32'(l2), 32'd0);
    @(negedge clk); mov = 1'b0;
    $display("disabled request held for 10 edges");
    do_txn(1'b1, 2'd0, 1'b0, 9'h034, 32'h0, d2, e2, l2, d0, e0, l0);
    chk("disabled_nowrite", d2, 32'h01020304);
    chk("disabled_nowrite0", d0, 32'h01020304);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
